// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and decode helper for the multiply/divide
// issue controller and its timeout counter.
package multdiv_pkg;

  localparam logic [4:0]  OP_RTYPE     = 5'b00000;
  localparam logic [4:0]  ALU_MULT     = 5'b00110;
  localparam logic [4:0]  ALU_DIV      = 5'b00111;
  localparam logic [4:0]  RSTATUS_REG  = 5'd30;
  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  function automatic logic is_multdiv(input logic       valid,
                                      input logic [4:0] opc,
                                      input logic [4:0] alu);
    return valid && (opc == OP_RTYPE) && ((alu == ALU_MULT) || (alu == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_ctrl_counter.sv
// WAIT-state cycle counter: synchronous clear, count enable and a terminal
// flag raised when the count reaches TIMEOUT-1.
module md_timeout_counter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [5:0] TC_VALUE = 6'(TIMEOUT - 1);

  logic [5:0] count_q;
  logic [5:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 6'd0;
    end else if (enable) begin
      count_d = count_q + 6'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 6'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VALUE);

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage controller that hands mult/div instructions to a multicycle
// unit, stalls the front of the pipe while it runs, and issues the writeback.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  ALUop,
  input  logic [4:0]  rd,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic accept_s;
  logic cnt_clear_s;
  logic cnt_en_s;
  logic cnt_tc_s;

  assign accept_s    = is_multdiv(issue_valid, opcode, ALUop);
  assign md_operandA = opa_q;
  assign md_operandB = opb_q;

  md_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .tc     (cnt_tc_s)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rd_d         = rd_q;
    result_d     = result_q;
    exc_d        = exc_q;
    cnt_clear_s  = 1'b0;
    cnt_en_s     = 1'b0;
    stall        = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    wb_reg       = 5'd0;
    wb_data      = 32'd0;

    case (state_q)
      ST_IDLE: begin
        // Stall is raised in the accept cycle itself, but never while reset is held.
        if (accept_s && !reset) begin
          op_d    = (ALUop == ALU_DIV) ? OP_DIV : OP_MULT;
          opa_d   = operandA;
          opb_d   = operandB;
          rd_d    = rd;
          exc_d   = 1'b0;
          stall   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        stall        = 1'b1;
        md_ctrl_MULT = (op_q == OP_MULT);
        md_ctrl_DIV  = (op_q == OP_DIV);
        cnt_clear_s  = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        stall    = 1'b1;
        cnt_en_s = 1'b1;
        // A ready result wins over a timeout landing in the same cycle.
        if (md_resultRDY) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = ST_WB;
        end else if (cnt_tc_s) begin
          exc_d   = 1'b1;
          state_d = ST_WB;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        if (exc_q) begin
          wb_valid = 1'b1;
          wb_reg   = RSTATUS_REG;
          wb_data  = (op_q == OP_DIV) ? RSTATUS_DIV : RSTATUS_MULT;
        end else begin
          wb_valid = (rd_q != 5'd0);
          wb_reg   = rd_q;
          wb_data  = result_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MULT;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed vector table, ignored-instruction
// table, mid-operation reset, and randomized operations against a timeline model.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  opcode;
  logic [4:0]  ALUop;
  logic [4:0]  rd;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .opcode       (opcode),
    .ALUop        (ALUop),
    .rd           (rd),
    .operandA     (operandA),
    .operandB     (operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;

  // rdy_at: WAIT cycle (1-based) in which the unit answers; 0 or >TIMEOUT = never.
  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          rdy_at;
    logic [31:0] res;
    logic        exc;
    logic        rdy_in_start;
    logic        exp_valid;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [4:0] opc;
    logic [4:0] alu;
  } ign_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected writeback from the architectural rules.
  function automatic void model(input vec_t v, output logic valid, output logic [4:0] wreg,
                                output logic [31:0] data);
    logic answered;
    logic exc_eff;
    answered = (v.rdy_at >= 1) && (v.rdy_at <= TIMEOUT);
    exc_eff  = answered ? v.exc : 1'b1;
    if (exc_eff) begin
      valid = 1'b1;
      wreg  = 5'd30;
      data  = v.is_div ? 32'd5 : 32'd4;
    end else begin
      valid = (v.rd != 5'd0);
      wreg  = v.rd;
      data  = v.res;
    end
  endfunction

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    opcode       = 5'd0;
    ALUop        = 5'd0;
    rd           = 5'd0;
    operandA     = 32'd0;
    operandB     = 32'd0;
    md_resultRDY = 1'b0;
    md_result    = 32'd0;
    md_exception = 1'b0;
  endtask

  // Cycle 0 accepts, cycle 1 is START, 2..w+1 WAIT, w+2 WB, then IDLE.
  task automatic run_op(input vec_t v, input string tag);
    int   w;
    int   bad_stall = 0;
    int   bad_mult = 0;
    int   bad_div = 0;
    int   bad_wbv = 0;
    int   bad_opnd = 0;
    logic act_valid = 1'b0;
    logic [4:0]  act_reg = 5'd0;
    logic [31:0] act_data = 32'd0;
    w = ((v.rdy_at >= 1) && (v.rdy_at <= TIMEOUT)) ? v.rdy_at : TIMEOUT;
    for (int c = 0; c <= w + 4; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) begin
        issue_valid = 1'b1;
        opcode      = OP_RTYPE;
        ALUop       = v.is_div ? ALU_DIV : ALU_MULT;
        rd          = v.rd;
        operandA    = v.a;
        operandB    = v.b;
      end else if (c <= w + 2) begin
        issue_valid = 1'b1;
        opcode      = OP_RTYPE;
        ALUop       = ($urandom_range(0, 1) == 1) ? ALU_DIV : ALU_MULT;
        rd          = 5'($urandom);
        operandA    = $urandom;
        operandB    = $urandom;
      end else begin
        issue_valid = 1'b0;
      end
      md_resultRDY = 1'b0;
      md_result    = $urandom;
      md_exception = 1'($urandom);
      if ((c == 1) && v.rdy_in_start) md_resultRDY = 1'b1;
      if ((c >= 2) && (c - 1 == v.rdy_at)) begin
        md_resultRDY = 1'b1;
        md_result    = v.res;
        md_exception = v.exc;
      end
      #4;
      if (stall !== (c <= w + 1)) bad_stall++;
      if (md_ctrl_MULT !== ((c == 1) && !v.is_div)) bad_mult++;
      if (md_ctrl_DIV !== ((c == 1) && v.is_div)) bad_div++;
      if ((c >= 1) && (c <= w + 2) && ((md_operandA !== v.a) || (md_operandB !== v.b))) bad_opnd++;
      if (c == w + 2) begin
        act_valid = wb_valid;
        act_reg   = wb_reg;
        act_data  = wb_data;
      end else if (wb_valid !== 1'b0) begin
        bad_wbv++;
      end
    end
    idle_inputs();
    check({tag, " stall cycles wrong"}, bad_stall, 0);
    check({tag, " mult pulse cycles wrong"}, bad_mult, 0);
    check({tag, " div pulse cycles wrong"}, bad_div, 0);
    check({tag, " operand hold cycles wrong"}, bad_opnd, 0);
    check({tag, " stray wb_valid cycles"}, bad_wbv, 0);
    check({tag, " wb_valid in WB"}, {31'd0, act_valid}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      check({tag, " wb_reg"}, {27'd0, act_reg}, {27'd0, v.exp_reg});
      check({tag, " wb_data"}, act_data, v.exp_data);
    end
  endtask

  vec_t vecs[6];
  ign_t igns[5];

  initial begin
    vec_t rv;
    // is_div a b rd rdy_at res exc rdy_in_start exp_valid exp_reg exp_data
    vecs[0] = '{1'b0, 32'd7,  32'd6, 5'd5,  17, 32'd42,  1'b0, 1'b0, 1'b1, 5'd5,  32'd42};
    vecs[1] = '{1'b1, 32'd9,  32'd0, 5'd8,  10, 32'd0,   1'b1, 1'b0, 1'b1, 5'd30, 32'd5};
    vecs[2] = '{1'b0, 32'd3,  32'd4, 5'd9,  0,  32'd0,   1'b0, 1'b0, 1'b1, 5'd30, 32'd4};
    vecs[3] = '{1'b0, 32'd1,  32'd9, 5'd3,  40, 32'd9,   1'b0, 1'b0, 1'b1, 5'd3,  32'd9};
    vecs[4] = '{1'b0, 32'd11, 32'd2, 5'd0,  5,  32'd123, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0};
    vecs[5] = '{1'b1, 32'd77, 32'd1, 5'd12, 1,  32'd77,  1'b0, 1'b1, 1'b1, 5'd12, 32'd77};
    igns[0] = '{1'b0, 5'b00000, 5'b00110};
    igns[1] = '{1'b1, 5'b00001, 5'b00110};
    igns[2] = '{1'b1, 5'b00000, 5'b00101};
    igns[3] = '{1'b1, 5'b00000, 5'b01000};
    igns[4] = '{1'b1, 5'b00100, 5'b00111};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    issue_valid = 1'b1;
    opcode      = OP_RTYPE;
    ALUop       = ALU_MULT;
    operandA    = 32'd55;
    #4;
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset md_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
    check("reset md_operandA", md_operandA, 32'd0);
    check("reset md_operandB", md_operandB, 32'd0);
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      issue_valid = igns[i].valid;
      opcode      = igns[i].opc;
      ALUop       = igns[i].alu;
      rd          = 5'd7;
      #4;
      check($sformatf("ignored%0d stall", i), {31'd0, stall}, 32'd0);
      @(posedge clock);
      #1;
      idle_inputs();
      #4;
      check($sformatf("ignored%0d no start", i), {30'd0, md_ctrl_MULT, md_ctrl_DIV, stall}, 32'd0);
    end

    // Reset in the middle of WAIT abandons the operation.
    @(posedge clock);
    #1;
    issue_valid = 1'b1;
    opcode      = OP_RTYPE;
    ALUop       = ALU_MULT;
    rd          = 5'd4;
    operandA    = 32'd11;
    operandB    = 32'd12;
    @(posedge clock);
    #1;
    idle_inputs();
    repeat (4) @(posedge clock);
    #1;
    check("pre-reset stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid-wait reset stall", {31'd0, stall}, 32'd0);
    check("mid-wait reset operandA", md_operandA, 32'd0);
    begin
      int wb_seen = 0;
      md_resultRDY = 1'b1;
      md_result    = 32'd99;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        if (wb_valid !== 1'b0 || stall !== 1'b0) wb_seen++;
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        if (wb_valid !== 1'b0 || stall !== 1'b0) wb_seen++;
      end
      check("reset abandons op", wb_seen, 0);
    end
    run_op(vecs[0], "after-reset");

    for (int i = 0; i < 20; i++) begin
      rv.is_div       = 1'($urandom);
      rv.a            = $urandom;
      rv.b            = $urandom;
      rv.rd           = 5'($urandom);
      rv.rdy_at       = $urandom_range(0, 45);
      rv.res          = $urandom;
      rv.exc          = ($urandom_range(0, 3) == 0);
      rv.rdy_in_start = 1'($urandom);
      model(rv, rv.exp_valid, rv.exp_reg, rv.exp_data);
      run_op(rv, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
